// File: rtl/quot_bcd_pkg.sv
// Shared constants, state encoding and a digit-count helper for the
// quotient-to-BCD converter slice.
package quot_bcd_pkg;

  localparam int DW    = 32;          // quotient width
  localparam int ND    = 10;          // BCD digits needed for DW bits
  localparam int RW    = 16;          // remainder width (passed through)
  localparam int CNT_W = 5;           // step counter width, counts DW-1..0
  localparam int DIG_W = 4;           // bits per BCD digit
  localparam int BCD_W = ND * DIG_W;  // packed BCD width

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Number of significant digits: 1 + index of the highest nonzero digit.
  // An all-zero value still reports one digit so "0" can be displayed.
  function automatic logic [3:0] count_digits(input logic [BCD_W-1:0] bcd);
    logic [3:0] n;
    n = 4'd1;
    for (int k = 1; k < ND; k++) begin
      if (bcd[k*DIG_W +: DIG_W] != '0) n = 4'(k + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import quot_bcd_pkg::*;
(
  input  logic [DIG_W-1:0] din,
  output logic [DIG_W-1:0] dout
);

  // 4-bit arithmetic only; no carry leaves the digit
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/quot_bcd_converter.sv
// Sequential binary-to-BCD converter behind the 32-bit divider.
// Converts one quotient bit per clock (double dabble), passes the remainder
// through, and keeps a one-entry buffer so a result arriving mid-conversion
// is queued rather than lost. Back-to-back jobs run with no idle gap.
module quot_bcd_converter
  import quot_bcd_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [31:0]   in_quotient,
  input  logic [15:0]   in_remainder,
  input  logic          clr_ovf,
  output logic          out_valid,
  output logic [39:0]   out_bcd,
  output logic [3:0]    out_ndigits,
  output logic [15:0]   out_remainder,
  output logic          busy,
  output logic          overflow
);

  localparam logic [CNT_W-1:0] CNT_LAST_STEP = CNT_W'(DW - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DW-1:0]      bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [RW-1:0]      rem_q;

  logic               buf_full;
  logic [DW-1:0]      buf_quot;
  logic [RW-1:0]      buf_rem;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_nxt;
  logic [DW-1:0]      bin_nxt;

  logic               done_step;
  logic               start_buf;
  logic               start_in;
  logic               buf_wr;
  logic               drop;

  // Per-digit +3 correction on the pre-shift BCD value
  for (genvar k = 0; k < ND; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd_q[k*DIG_W +: DIG_W]),
      .dout (bcd_adj[k*DIG_W +: DIG_W])
    );
  end

  // One double-dabble step: {bcd, bin} shifted left by one after adjust
  assign bcd_nxt = {bcd_adj[BCD_W-2:0], bin_q[DW-1]};
  assign bin_nxt = {bin_q[DW-2:0], 1'b0};

  assign busy = (state == SHIFT);

  // Job scheduling decisions for this edge
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    done_step = 1'b0;
    start_buf = 1'b0;
    start_in  = 1'b0;
    buf_wr    = 1'b0;
    drop      = 1'b0;
    if (state == IDLE) begin
      start_in = in_valid;
    end else begin
      done_step = (cnt == '0);
      if (done_step) begin
        // The buffered job has priority; a simultaneous arrival refills it
        start_buf = buf_full;
        start_in  = !buf_full && in_valid;
        buf_wr    = buf_full && in_valid;
      end else if (in_valid) begin
        buf_wr = !buf_full;
        drop   = buf_full;
      end
    end
  end

  // Conversion engine: FSM, step counter, shift registers, remainder latch
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      bin_q <= '0;
      bcd_q <= '0;
      rem_q <= '0;
    end else if (start_buf) begin
      state <= SHIFT;
      cnt   <= CNT_LAST_STEP;
      bin_q <= buf_quot;
      bcd_q <= '0;
      rem_q <= buf_rem;
    end else if (start_in) begin
      state <= SHIFT;
      cnt   <= CNT_LAST_STEP;
      bin_q <= in_quotient;
      bcd_q <= '0;
      rem_q <= in_remainder;
    end else if (state == SHIFT) begin
      bin_q <= bin_nxt;
      bcd_q <= bcd_nxt;
      if (done_step) begin
        state <= IDLE;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // One-entry holding buffer for a result that arrives mid-conversion
  // NOTE: the buffer data is reset along with its full flag; it is only two
  // registers wide, and a defined value keeps reset state easy to inspect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full <= 1'b0;
      buf_quot <= '0;
      buf_rem  <= '0;
    end else if (buf_wr) begin
      buf_full <= 1'b1;
      buf_quot <= in_quotient;
      buf_rem  <= in_remainder;
    end else if (start_buf) begin
      buf_full <= 1'b0;
    end
  end

  // Result registers: captured on the final step, held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_bcd       <= '0;
      out_ndigits   <= '0;
      out_remainder <= '0;
    end else begin
      out_valid <= done_step;
      if (done_step) begin
        out_bcd       <= bcd_nxt;
        out_ndigits   <= count_digits(bcd_nxt);
        out_remainder <= rem_q;
      end
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quot_bcd_converter.sv
// Scoreboard bench for quot_bcd_converter: directed cases plus randomized
// jobs with random gaps, checked against a decimal-arithmetic reference.
module tb_quot_bcd_converter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_quotient;
  logic [15:0] in_remainder;
  logic        clr_ovf;
  logic        out_valid;
  logic [39:0] out_bcd;
  logic [3:0]  out_ndigits;
  logic [15:0] out_remainder;
  logic        busy;
  logic        overflow;

  quot_bcd_converter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_quotient   (in_quotient),
    .in_remainder  (in_remainder),
    .clr_ovf       (clr_ovf),
    .out_valid     (out_valid),
    .out_bcd       (out_bcd),
    .out_ndigits   (out_ndigits),
    .out_remainder (out_remainder),
    .busy          (busy),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [39:0] bcd;
    logic [3:0]  nd;
    logic [15:0] rem;
    int          done;
  } exp_t;

  exp_t sb[$];     // expected results, in completion order
  int   pend[$];   // completion cycles of jobs accepted but not finished
  logic model_ovf = 1'b0;
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference conversion by repeated division by ten
  function automatic logic [39:0] ref_bcd(input logic [31:0] q);
    longint v;
    logic [39:0] r;
    v = longint'(q);
    r = '0;
    for (int k = 0; k < 10; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_nd(input logic [31:0] q);
    longint v;
    int n;
    v = longint'(q);
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return 4'(n);
  endfunction

  // Present one pair for the next edge; the model decides whether it is
  // accepted (fewer than two jobs outstanding) and when it will complete.
  task automatic drive(input logic [31:0] q, input logic [15:0] r);
    int t;
    exp_t e;
    t = cyc + 1;
    while (pend.size() > 0 && pend[0] <= t) void'(pend.pop_front());
    if (pend.size() < 2) begin
      e.done = (pend.size() == 0) ? t + 32 : pend[$] + 32;
      e.bcd  = ref_bcd(q);
      e.nd   = ref_nd(q);
      e.rem  = r;
      pend.push_back(e.done);
      sb.push_back(e);
    end else begin
      model_ovf = 1'b1;
    end
    in_valid     = 1'b1;
    in_quotient  = q;
    in_remainder = r;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_ovf();
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    model_ovf = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 400) begin
      idle(1);
      n++;
    end
    check("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every out_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("out_bcd", 64'(out_bcd), 64'(mon_e.bcd));
        check("out_ndigits", 64'(out_ndigits), 64'(mon_e.nd));
        check("out_remainder", 64'(out_remainder), 64'(mon_e.rem));
        check("out_time", 64'(cyc), 64'(mon_e.done));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    logic [31:0] q;
    longint p;
    int gap;

    rst_n = 1'b0; in_valid = 1'b0; in_quotient = '0; in_remainder = '0; clr_ovf = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_out_bcd", 64'(out_bcd), 64'd0);
    check("rst_out_ndigits", 64'(out_ndigits), 64'd0);
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed conversions, each run alone
    drive(32'd0, 16'd7);
    check("busy_after_capture", 64'(busy), 64'd1);
    drain();
    drive(32'd1234567890, 16'h1234);
    idle(40);
    check("held_bcd_1234567890", 64'(out_bcd), 64'h1234567890);
    check("held_nd_1234567890", 64'(out_ndigits), 64'd10);
    check("idle_busy", 64'(busy), 64'd0);
    drive(32'd305, 16'd1);
    drain();
    drive(32'hFFFF_FFFF, 16'hFFFF);
    idle(40);
    check("held_bcd_max", 64'(out_bcd), 64'h4294967295);
    check("held_rem_max", 64'(out_remainder), 64'hFFFF);

    // Three arrivals on consecutive edges: third one is dropped
    drive(32'd11, 16'd1);
    drive(32'd22, 16'd2);
    check("ovf_before_drop", 64'(overflow), 64'd0);
    drive(32'd33, 16'd3);
    check("ovf_after_drop", 64'(overflow), 64'(model_ovf));
    idle(5);
    check("ovf_sticky", 64'(overflow), 64'd1);
    clear_ovf();
    check("ovf_cleared", 64'(overflow), 64'd0);
    drain();

    // Second job lands exactly on the completion edge: no gap, no drop
    bad = 1'b0;
    drive(32'd9, 16'd9);
    repeat (31) begin
      idle(1);
      if (!busy) bad = 1'b1;
    end
    drive(32'd10, 16'd10);
    repeat (31) begin
      if (!busy) bad = 1'b1;
      idle(1);
    end
    check("busy_no_gap", 64'(bad), 64'd0);
    check("ovf_no_drop", 64'(overflow), 64'd0);
    drain();

    // Asynchronous reset mid-conversion discards the job
    drive(32'd777, 16'd5);
    idle(10);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_out_bcd", 64'(out_bcd), 64'd0);
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    sb.delete();
    pend.delete();
    model_ovf = 1'b0;
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    idle(30);
    drive(32'd4321, 16'd8);
    drain();

    // Randomized jobs with random spacing, including drops
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: q = $urandom_range(0, 999);
        1: begin
          p = 1;
          repeat ($urandom_range(0, 9)) p = p * 10;
          q = 32'(($urandom_range(0, 1) == 1) ? p - 1 : p);
        end
        default: q = $urandom;
      endcase
      drive(q, 16'($urandom));
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 45);
      idle(gap);
    end
    drain();
    check("ovf_random", 64'(overflow), 64'(model_ovf));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/quot_bcd_converter.md
Name: quot_bcd_converter

Overview:
- Sequential binary-to-BCD converter placed directly downstream of the 32-bit divider.
- Captures the divider's quotient and remainder on its one-cycle done pulse.
- Converts the 32-bit quotient to 10 packed BCD digits using shift-and-add-3 (double dabble), one bit per clock.
- Presents digits, a significant-digit count and the pass-through remainder to the display/UART formatting stage, with a one-entry holding buffer so a second result arriving mid-conversion is not lost.

Parameters:
- DW, 32, quotient width in bits (fixed at 32 for this revision).
- ND, 10, number of BCD digits (ceil(DW*log10(2))).
- RW, 16, remainder width in bits, passed through unconverted.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  one-cycle pulse, wired to divider done.
- in_quotient  input  32  quotient, sampled when in_valid=1.
- in_remainder  input  16  remainder, sampled when in_valid=1.
- clr_ovf  input  1  synchronous clear of the overflow flag.
- out_valid  output  1  one-cycle pulse, out_* fields valid.
- out_bcd  output  40  packed BCD; digit k at [4k+3:4k]; digit 0 is least significant.
- out_ndigits  output  4  significant digits, 1..10 (value 0 reports 1).
- out_remainder  output  16  remainder belonging to out_bcd.
- busy  output  1  engine converting.
- overflow  output  1  sticky: a result was dropped.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; buffer empty; counter 0. Takes effect immediately, including mid-conversion; an in-flight conversion is discarded and no out_valid is produced.
- States: IDLE, SHIFT.
- Capture in IDLE: at edge E with in_valid=1, load in_quotient into the bin shift register, clear the bcd register, latch in_remainder, set cnt=31, go to SHIFT, busy=1.
- One step per edge in SHIFT:
  - each 4-bit bcd digit >=5 gets +3;
  - then {bcd[39:0], bin[31:0]} shifts left by 1.
  - Digit adjust uses the pre-shift value. All arithmetic is 4-bit per digit, with no carry between digits.
- Latency: steps occur at edges E+1..E+32. At edge E+32 (cnt==0), register out_bcd, out_ndigits and out_remainder, and set out_valid=1 for that single cycle. out_* hold their values until the next completion.
- out_ndigits = 1 + index of the highest nonzero digit; all-zero gives 1. Computed from the final bcd value.
- busy is 1 from edge E through edge E+32 unless a new job is loaded at that edge (see below); otherwise busy returns to 0 at E+32 and the block goes to IDLE.
- Holding buffer (1 entry, quotient+remainder):
  - in_valid while in SHIFT with buffer empty: store the pair in the buffer.
  - Completion edge with buffer full: load the buffer into the engine at that same edge (stay in SHIFT, cnt=31, busy stays 1). If in_valid is also 1 at that edge, the new pair fills the buffer (it stays full); no drop.
  - Completion edge with buffer empty and in_valid=1: load in_* directly into the engine; stay in SHIFT.
  - Result: back-to-back jobs have no idle gap; successive out_valid pulses are exactly 32 cycles apart.
- Overflow:
  - in_valid=1 in SHIFT, buffer full and not a completion edge: drop the pair and set overflow=1.
  - overflow clears only on clr_ovf=1 (sync) or reset.
  - If clr_ovf and a drop occur in the same cycle, overflow is set (set wins).
- in_valid in IDLE never sets overflow.

Decomposition:
- Package quot_bcd_pkg: constants DW=32, ND=10, RW=16, CNT_W=5; state enum {IDLE, SHIFT}; localparam for BCD digit width 4.
- Sub-module bcd_digit_adj: combinational 4-bit in, 4-bit out (+3 if >=5). Instantiated ND times via generate.
- Top holds the FSM, counter, shift register, buffer and output registers.

Test Plan:
- Reset then in_valid with quotient=0, remainder=7 -> out_valid exactly 32 cycles after capture edge; out_bcd=0x0000000000, out_ndigits=1, out_remainder=7.
- quotient=1234567890 -> out_bcd=0x1234567890, out_ndigits=10. quotient=305 -> out_bcd=0x0000000305, out_ndigits=3.
- quotient=0xFFFFFFFF, remainder=0xFFFF -> out_bcd=0x4294967295, out_ndigits=10, out_remainder=0xFFFF.
- in_valid at E (q=11), E+1 (q=22), E+2 (q=33) -> out_valid at E+32 (0x11) and E+64 (0x22); 33 dropped; overflow=1 from E+3 until clr_ovf pulse, then 0.
- in_valid at E (q=9), then again at exactly E+32 (q=10) -> out_valid at E+32 (0x09) and E+64 (0x10); busy never drops; overflow stays 0.
- in_valid at E, rst_n=0 asynchronously at E+10.5 for 2 cycles -> outputs and busy go 0 immediately; no out_valid at E+32; a new in_valid after reset converts correctly.
